// File: rtl/crc_pkg.sv
// Shared types and constants for the streaming CRC engine and the frame parser.
package crc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } crc_state_e;

  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHK = 1'b1;

  // Legacy encoder CRC is a plain byte XOR, i.e. x^8+1.
  localparam logic [7:0] CRC8_XOR   = 8'h01;
  localparam logic [7:0] CRC8_SMBUS = 8'h07;

  localparam logic [7:0] DEF_POLY   = CRC8_XOR;
  localparam logic [7:0] DEF_INIT   = 8'h00;
  localparam logic [7:0] DEF_XOROUT = 8'h00;

endpackage : crc_pkg

// File: rtl/crc_step.sv
// One-symbol CRC update: non-reflected LFSR, data processed MSB first.
module crc_step #(
  parameter int unsigned     CRC_W  = 8,
  parameter int unsigned     DATA_W = 8,
  parameter logic [CRC_W-1:0] POLY  = CRC_W'(8'h01)
) (
  input  logic [CRC_W-1:0]  crc_in,
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  crc_out
);

  logic [CRC_W-1:0] w_crc;
  logic             w_fb;

  always_comb begin
    // NOTE: w_crc is assigned before the loop reads it, so no latch is inferred,
    // and blocking assignments let each bit see the previous bit's result.
    w_crc = crc_in;
    w_fb  = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      w_fb  = w_crc[CRC_W-1] ^ data[i];
      w_crc = (w_crc << 1) ^ (w_fb ? POLY : '0);
    end
    crc_out = w_crc;
  end

endmodule : crc_step

// File: rtl/crc_stream_engine.sv
// Byte-serial CRC generator/checker between the frame assembler/parser and the line shifter.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int unsigned      CRC_W     = 8,
  parameter int unsigned      DATA_W    = 8,
  parameter logic [CRC_W-1:0] POLY      = CRC_W'(DEF_POLY),
  parameter logic [CRC_W-1:0] INIT      = CRC_W'(DEF_INIT),
  parameter logic [CRC_W-1:0] XOROUT    = CRC_W'(DEF_XOROUT),
  parameter int unsigned      MAX_BYTES = 16,
  parameter int unsigned      CNT_W     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              mode_chk,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              crc_valid,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_ok,
  output logic              len_err,
  output logic [CNT_W-1:0]  byte_cnt
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

  crc_state_e       r_state;
  logic             r_mode;
  logic [CRC_W-1:0] r_crc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ready;
  logic             r_crc_valid;
  logic [CRC_W-1:0] r_crc_out;
  logic             r_crc_ok;
  logic             r_len_err;

  logic             w_accept;
  logic             w_first;
  logic             w_mode;
  logic [CNT_W-1:0] w_cnt_base;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CRC_W-1:0] w_crc_fold;
  logic [CRC_W-1:0] w_result;
  logic             w_len_err;
  logic             w_ok;

  crc_step #(
    .CRC_W  (CRC_W),
    .DATA_W (DATA_W),
    .POLY   (POLY)
  ) u_step (
    .crc_in  (r_crc),
    .data    (s_data),
    .crc_out (w_crc_fold)
  );

  // Mode and byte count come straight from the inputs on the first byte of a frame.
  assign w_accept   = s_valid & r_ready;
  assign w_first    = (r_state == ST_IDLE);
  assign w_mode     = w_first ? mode_chk : r_mode;
  assign w_cnt_base = w_first ? '0 : r_cnt;
  assign w_cnt_next = (&w_cnt_base) ? w_cnt_base : w_cnt_base + CNT_W'(1);
  assign w_len_err  = (w_cnt_next > MAX_CNT);

  // In CHK mode the trailing byte is the received CRC, so it is compared, not folded.
  assign w_result = ((w_mode == MODE_CHK) ? r_crc : w_crc_fold) ^ XOROUT;
  assign w_ok     = !w_len_err &&
                    ((w_mode == MODE_GEN) || (s_data[CRC_W-1:0] == w_result));

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mode      <= MODE_GEN;
      r_crc       <= INIT;
      r_cnt       <= '0;
      r_ready     <= 1'b1;
      r_crc_valid <= 1'b0;
      r_crc_out   <= '0;
      r_crc_ok    <= 1'b0;
      r_len_err   <= 1'b0;
    end else begin
      r_crc_valid <= 1'b0;
      if (clr) begin
        r_state <= ST_IDLE;
        r_crc   <= INIT;
        r_cnt   <= '0;
        r_ready <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE, ST_ACC: begin
            if (w_accept) begin
              r_cnt <= w_cnt_next;
              if (w_first) r_mode <= mode_chk;
              if (s_last) begin
                r_state     <= ST_DONE;
                r_ready     <= 1'b0;
                r_crc       <= INIT;
                r_crc_valid <= 1'b1;
                r_crc_out   <= w_result;
                r_crc_ok    <= w_ok;
                r_len_err   <= w_len_err;
              end else begin
                r_state <= ST_ACC;
                r_crc   <= w_crc_fold;
              end
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end
          default: begin
            r_state <= ST_IDLE;
            r_crc   <= INIT;
            r_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign s_ready   = r_ready;
  assign crc_valid = r_crc_valid;
  assign crc_out   = r_crc_out;
  assign crc_ok    = r_crc_ok;
  assign len_err   = r_len_err;
  assign byte_cnt  = r_cnt;

endmodule : crc_stream_engine

// File: tb/tb_crc_stream_engine.sv
// Scoreboard bench: three engine instances share one stimulus stream; one is observed per scenario.
module tb_crc_stream_engine;
  import crc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       mode_chk = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic [7:0] s_data = 8'h00;

  logic [2:0] s_ready_v, crc_valid_v, crc_ok_v, len_err_v;
  logic [7:0] crc_out_v [3];
  logic [4:0] byte_cnt_v [3];

  int sel = 0;
  logic       m_s_ready, m_crc_valid, m_crc_ok, m_len_err;
  logic [7:0] m_crc_out;
  logic [4:0] m_byte_cnt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] crc;
    logic       ok;
    logic       len;
    logic [4:0] cnt;
    string      name;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  crc_stream_engine #(.POLY(CRC8_XOR)) u_xor (
    .clk(clk), .rst_n(rst_n), .clr(clr), .mode_chk(mode_chk),
    .s_valid(s_valid), .s_ready(s_ready_v[0]), .s_data(s_data), .s_last(s_last),
    .crc_valid(crc_valid_v[0]), .crc_out(crc_out_v[0]), .crc_ok(crc_ok_v[0]),
    .len_err(len_err_v[0]), .byte_cnt(byte_cnt_v[0]));

  crc_stream_engine #(.POLY(CRC8_SMBUS)) u_smbus (
    .clk(clk), .rst_n(rst_n), .clr(clr), .mode_chk(mode_chk),
    .s_valid(s_valid), .s_ready(s_ready_v[1]), .s_data(s_data), .s_last(s_last),
    .crc_valid(crc_valid_v[1]), .crc_out(crc_out_v[1]), .crc_ok(crc_ok_v[1]),
    .len_err(len_err_v[1]), .byte_cnt(byte_cnt_v[1]));

  crc_stream_engine #(.POLY(CRC8_XOR), .MAX_BYTES(4)) u_max4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .mode_chk(mode_chk),
    .s_valid(s_valid), .s_ready(s_ready_v[2]), .s_data(s_data), .s_last(s_last),
    .crc_valid(crc_valid_v[2]), .crc_out(crc_out_v[2]), .crc_ok(crc_ok_v[2]),
    .len_err(len_err_v[2]), .byte_cnt(byte_cnt_v[2]));

  always_comb begin
    m_s_ready   = s_ready_v[sel];
    m_crc_valid = crc_valid_v[sel];
    m_crc_out   = crc_out_v[sel];
    m_crc_ok    = crc_ok_v[sel];
    m_len_err   = len_err_v[sel];
    m_byte_cnt  = byte_cnt_v[sel];
  end

  // Monitor: crc_valid must follow an accepted s_last by exactly one cycle; results pop the scoreboard.
  initial begin : monitor
    logic pend;
    exp_t e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        n_checks++;
        if (m_crc_valid !== pend) begin
          n_errors++;
          $display("FAIL crc_valid_timing dut%0d: got %b want %b at %0t", sel, m_crc_valid, pend, $time);
        end
        if (m_crc_valid === 1'b1) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_result dut%0d: got crc=%h with empty scoreboard", sel, m_crc_out);
          end else begin
            e = sb.pop_front();
            if ({m_crc_out, m_crc_ok, m_len_err, m_byte_cnt} !== {e.crc, e.ok, e.len, e.cnt}) begin
              n_errors++;
              $display("FAIL %s: got crc=%h ok=%b len=%b cnt=%0d, want crc=%h ok=%b len=%b cnt=%0d",
                       e.name, m_crc_out, m_crc_ok, m_len_err, m_byte_cnt, e.crc, e.ok, e.len, e.cnt);
            end
          end
        end
        pend = s_valid & m_s_ready & s_last & ~clr;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drivers run from posedge+1; s_ready is registered, so its value then governs the next edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, output int waits);
    logic rdy;
    waits   = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    forever begin
      rdy = m_s_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      waits++;
      if (waits > 8) begin
        n_checks++;
        n_errors++;
        $display("FAIL ready_timeout: got s_ready=0 for %0d cycles want accept", waits);
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input int max_gap, output int first_waits);
    int w;
    first_waits = 0;
    for (int i = 0; i < bytes.size(); i++) begin
      if (i > 0 && max_gap > 0) idle($urandom_range(0, max_gap));
      send_byte(bytes[i], (i == bytes.size() - 1), w);
      if (i == 0) first_waits = w;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain_timeout: got %0d pending results want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({s_ready_v[k], crc_valid_v[k], crc_out_v[k], crc_ok_v[k], len_err_v[k], byte_cnt_v[k]}
          !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0}) begin
        n_errors++;
        $display("FAIL reset_values dut%0d: got rdy=%b v=%b crc=%h ok=%b len=%b cnt=%0d want 1 0 00 0 0 0",
                 k, s_ready_v[k], crc_valid_v[k], crc_out_v[k], crc_ok_v[k], len_err_v[k], byte_cnt_v[k]);
      end
    end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_legacy_gen();
    int w;
    sel = 0; mode_chk = MODE_GEN;
    sb.push_back('{8'h02, 1'b1, 1'b0, 5'd4, "legacy_gen"});
    send_frame('{8'h02, 8'h11, 8'h22, 8'h33}, 0, w);
    sb.push_back('{8'h5A, 1'b1, 1'b0, 5'd1, "single_gen"});
    send_frame('{8'h5A}, 0, w);
    drain();
  endtask

  task automatic test_legacy_chk();
    int w;
    sel = 0; mode_chk = MODE_CHK;
    sb.push_back('{8'h02, 1'b1, 1'b0, 5'd5, "chk_good"});
    send_frame('{8'h02, 8'h11, 8'h22, 8'h33, 8'h02}, 0, w);
    drain();
    sb.push_back('{8'h02, 1'b0, 1'b0, 5'd5, "chk_bad"});
    send_frame('{8'h02, 8'h11, 8'h22, 8'h33, 8'h03}, 0, w);
    drain();
    sb.push_back('{8'h00, 1'b1, 1'b0, 5'd1, "chk_single_good"});
    send_frame('{8'h00}, 0, w);
    sb.push_back('{8'h00, 1'b0, 1'b0, 5'd1, "chk_single_bad"});
    send_frame('{8'h5A}, 0, w);
    drain();
    mode_chk = MODE_GEN;
  endtask

  task automatic test_smbus_gen();
    int w;
    sel = 1; mode_chk = MODE_GEN;
    sb.push_back('{8'hF4, 1'b1, 1'b0, 5'd9, "smbus_check_string"});
    send_frame('{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39}, 0, w);
    drain();
  endtask

  task automatic test_back_to_back();
    int wa, wb;
    sel = 1; mode_chk = MODE_GEN;
    sb.push_back('{8'hF4, 1'b1, 1'b0, 5'd9, "b2b_first"});
    sb.push_back('{8'h07, 1'b1, 1'b0, 5'd1, "b2b_second"});
    send_frame('{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39}, 0, wa);
    send_frame('{8'h01}, 0, wb);
    n_checks++;
    if (wa !== 0) begin
      n_errors++;
      $display("FAIL b2b_idle_start: got %0d stall cycles want 0", wa);
    end
    n_checks++;
    if (wb !== 1) begin
      n_errors++;
      $display("FAIL b2b_bubble: got %0d stall cycles want 1", wb);
    end
    drain();
  endtask

  task automatic test_len_err();
    int w;
    sel = 2; mode_chk = MODE_GEN;
    sb.push_back('{8'h04, 1'b1, 1'b0, 5'd4, "len_at_max"});
    send_frame('{8'h01, 8'h02, 8'h03, 8'h04}, 0, w);
    sb.push_back('{8'h07, 1'b0, 1'b1, 5'd6, "len_over_max"});
    send_frame('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, 0, w);
    drain();
  endtask

  task automatic test_clr();
    int w;
    sel = 0; mode_chk = MODE_GEN;
    sb.push_back('{8'hFF, 1'b1, 1'b0, 5'd2, "clr_pre"});
    send_frame('{8'h5A, 8'hA5}, 0, w);
    drain();
    send_byte(8'h02, 1'b0, w);
    send_byte(8'h11, 1'b0, w);
    s_valid = 1'b1; s_data = 8'h22; clr = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0; clr = 1'b0;
    n_checks++;
    if ({m_s_ready, m_byte_cnt, m_crc_out, m_crc_ok} !== {1'b1, 5'd0, 8'hFF, 1'b1}) begin
      n_errors++;
      $display("FAIL clr_state: got rdy=%b cnt=%0d crc=%h ok=%b want 1 0 ff 1",
               m_s_ready, m_byte_cnt, m_crc_out, m_crc_ok);
    end
    idle(3);
    sb.push_back('{8'h02, 1'b1, 1'b0, 5'd4, "clr_init_reload"});
    send_frame('{8'h02, 8'h11, 8'h22, 8'h33}, 0, w);
    drain();
  endtask

  task automatic test_async_reset();
    int w;
    sel = 0; mode_chk = MODE_GEN;
    send_byte(8'h02, 1'b0, w);
    send_byte(8'h11, 1'b0, w);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({m_s_ready, m_crc_valid, m_crc_out, m_crc_ok, m_len_err, m_byte_cnt}
        !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0}) begin
      n_errors++;
      $display("FAIL async_reset: got rdy=%b v=%b crc=%h ok=%b len=%b cnt=%0d want 1 0 00 0 0 0",
               m_s_ready, m_crc_valid, m_crc_out, m_crc_ok, m_len_err, m_byte_cnt);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    sb.push_back('{8'h77, 1'b1, 1'b0, 5'd2, "post_reset_frame"});
    send_frame('{8'h33, 8'h44}, 0, w);
    drain();
  endtask

  task automatic test_gaps();
    int w;
    sel = 1; mode_chk = MODE_GEN;
    sb.push_back('{8'hF4, 1'b1, 1'b0, 5'd9, "gapped_frame"});
    send_frame('{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39}, 3, w);
    drain();
  endtask

  initial begin : main
    test_reset();
    test_legacy_gen();
    test_legacy_chk();
    test_smbus_gen();
    test_back_to_back();
    test_len_err();
    test_clr();
    test_async_reset();
    test_gaps();
    idle(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_crc_stream_engine
